sd_crc_gen: RTL and testbench
=============================

Name: sd_crc_gen

Overview:
Parametrised CRC generator for the SD host. It computes CRC7 for the CMD line or CRC16 for 1..8 DAT lanes in parallel, one independent register per lane. On request it serialises each lane's CRC MSB-first, then emits the end bit, so command and data framers share one engine. It sits between the SD command/data serialisers and the pad registers.

Parameters:
CRC_W, 7, CRC width in bits (7 for CMD, 16 for DAT).
POLY, 7'h09, generator polynomial without the implicit x^CRC_W term (16'h1021 for DAT).
LANES, 1, number of independent lanes (1, 4 or 8).

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-high
CLR  in  1  synchronous restart: zero all CRC registers, go to IDLE
IN  in  LANES  serial data bit per lane, MSB-first stream
EN  in  1  IN valid this cycle; absorb into CRC
FIN  in  1  pulse: end of payload, start CRC shift-out
OUT  out  LANES  serial CRC/end-bit per lane
OUT_VLD  out  1  OUT carries CRC or end bit this cycle
BUSY  out  1  high in SHIFT or ENDB
DONE  out  1  one-cycle pulse after the end bit
CRC  out  LANES*CRC_W  live CRC registers, lane 0 in LSBs

Behaviour:
- Reset (RST high, async): CRC=0, state IDLE, OUT=0, OUT_VLD=0, BUSY=0, DONE=0. The counter is cleared.
- All outputs are driven from registers only. There are no combinational paths from the inputs.
- Per-lane update when a bit is absorbed: fb=IN[l]^crc[CRC_W-1]; crc <= {crc[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0). The initial value is 0.
- States:
  - IDLE: EN absorbs a bit and moves to CALC. FIN goes to SHIFT, so an empty payload shifts out CRC=0.
  - CALC: EN absorbs a bit. FIN goes to SHIFT. If EN and FIN are high in the same cycle, the bit is absorbed first and SHIFT starts on the next cycle.
  - SHIFT: lasts exactly CRC_W cycles, tracked by counter cnt running 0..CRC_W-1.
    - OUT[l] is registered so that it presents crc[CRC_W-1] of lane l in each SHIFT cycle.
    - The register shifts left with a 0 filled in.
    - OUT_VLD=1 and BUSY=1.
    - EN and FIN are ignored.
  - ENDB: one cycle with OUT = all ones (end bit), OUT_VLD=1, BUSY=1. On the following cycle DONE=1 for one cycle, CRC=0, and the state returns to IDLE.
- OUT latency: the first CRC bit appears on OUT on the cycle after FIN is sampled. The complete sequence is CRC_W+1 OUT_VLD cycles, then DONE.
- CLR has priority over everything except RST. It aborts SHIFT/ENDB immediately, with no DONE, OUT_VLD=0 and OUT=0.
- A FIN arriving while BUSY is ignored and not queued.
- Lanes share control and never interact.

Optional Feature:
- Macro SD_CRC_CHECK_EN adds input CHK (1) and output ERR (LANES).
- When CHK is high at FIN, SHIFT becomes receive-check mode:
  - Each lane compares IN[l] against crc[CRC_W-1] every SHIFT cycle.
  - A mismatch sets sticky ERR[l].
  - In ENDB, IN[l]==0 also sets ERR[l] (missing end bit).
- ERR is valid with DONE and cleared by RST, CLR or the next FIN.
- Without the macro, CHK and ERR do not exist, no compare logic is generated, and IN is ignored during SHIFT/ENDB.

Test Plan:
- CRC_W=7, POLY=7'h09, LANES=1; 40 bits of 0x4000000000 (CMD0) then FIN -> OUT sequence 1001010 then 1 (byte 0x95), DONE one cycle after the end bit, CRC=0.
- Same config; 0x5100000000 (CMD17, arg 0) -> CRC shows 0x2A before FIN; OUT bits give byte 0x55.
- CRC_W=16, POLY=16'h1021, LANES=4; 512 bytes of 0xFF per lane -> each lane CRC=0x7FA1; 16 SHIFT cycles with OUT=4'hF/…, then ENDB OUT=4'hF, DONE.
- LANES=1, CRC16; "123456789" ASCII MSB-first -> CRC=0x31C3. EN and FIN together on the last bit -> same result, SHIFT starts the next cycle.
- CLR asserted mid-SHIFT (cycle 5) -> OUT_VLD=0 and BUSY=0 next cycle, no DONE, CRC=0. RST mid-CALC -> everything zero asynchronously.
- SD_CRC_CHECK_EN: feed CMD0 payload, then CHK=1 FIN with IN=1001010,1 -> ERR=0 at DONE. Repeat with bit 3 flipped -> ERR=1. Repeat with end bit 0 -> ERR=1.

Source files
------------

// File: rtl/sd_crc_gen_if.sv
// sd_crc_gen_if: control/data bundle between the SD framers and the CRC engine.
// With SD_CRC_CHECK_EN defined it also carries chk (check request) and err (per-lane result).
interface sd_crc_gen_if #(
   parameter int unsigned CRC_W = 7,
   parameter int unsigned LANES = 1
) ();

   logic                     clr;
   logic [LANES-1:0]         din;
   logic                     en;
   logic                     fin;
   logic [LANES-1:0]         dout;
   logic                     out_vld;
   logic                     busy;
   logic                     done;
   logic [LANES*CRC_W-1:0]   crc;
`ifdef SD_CRC_CHECK_EN
   logic                     chk;
   logic [LANES-1:0]         err;
`endif

   modport master (
      output clr, din, en, fin,
`ifdef SD_CRC_CHECK_EN
      output chk,
      input  err,
`endif
      input  dout, out_vld, busy, done, crc
   );

   modport slave (
      input  clr, din, en, fin,
`ifdef SD_CRC_CHECK_EN
      input  chk,
      output err,
`endif
      output dout, out_vld, busy, done, crc
   );

endinterface

// File: rtl/sd_crc_gen.sv
// sd_crc_gen: CRC7/CRC16 engine for the SD host, one register per lane, MSB-first shift-out
// followed by an end bit. Define SD_CRC_CHECK_EN to add receive-side CRC/end-bit checking.
module sd_crc_gen #(
   parameter int unsigned      CRC_W = 7,
   parameter logic [CRC_W-1:0] POLY  = 7'h09,
   parameter int unsigned      LANES = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   sd_crc_gen_if.slave  bus_io
);

   localparam int unsigned     CntW    = $clog2(CRC_W);
   localparam logic [CntW-1:0] CntLast = CntW'(CRC_W - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StCalc  = 2'd1;
   localparam logic [1:0] StShift = 2'd2;
   localparam logic [1:0] StEndb  = 2'd3;

   logic [1:0]                  state_q, state_d;
   logic [CntW-1:0]             cnt_q, cnt_d;
   logic [LANES-1:0][CRC_W-1:0] crc_q, crc_d, crc_abs;
   logic [LANES-1:0]            out_q, out_d;
   logic                        out_vld_q, out_vld_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
`ifdef SD_CRC_CHECK_EN
   logic                        chk_q, chk_d;
   logic [LANES-1:0]            err_q, err_d;
`endif

   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
      logic fb;
      fb = b ^ c[CRC_W-1];
      return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
   endfunction

   always_comb begin
      for (int l = 0; l < int'(LANES); l++) begin
         crc_abs[l] = crc_step(crc_q[l], bus_io.din[l]);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      crc_d     = crc_q;
      out_d     = '0;
      out_vld_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
`ifdef SD_CRC_CHECK_EN
      chk_d     = chk_q;
      err_d     = err_q;
`endif

      case (state_q)
         StIdle, StCalc: begin
            if (bus_io.en) begin
               crc_d   = crc_abs;
               state_d = StCalc;
            end
            // A bit absorbed with FIN is folded in before the first CRC bit is presented.
            if (bus_io.fin) begin
               state_d   = StShift;
               cnt_d     = '0;
               out_vld_d = 1'b1;
               busy_d    = 1'b1;
               for (int l = 0; l < int'(LANES); l++) begin
                  out_d[l] = crc_d[l][CRC_W-1];
                  crc_d[l] = {crc_d[l][CRC_W-2:0], 1'b0};
               end
`ifdef SD_CRC_CHECK_EN
               chk_d = bus_io.chk;
               err_d = '0;
`endif
            end
         end

         StShift: begin
            out_vld_d = 1'b1;
            busy_d    = 1'b1;
            if (cnt_q == CntLast) begin
               out_d   = '1;
               state_d = StEndb;
            end else begin
               cnt_d = cnt_q + 1'b1;
               for (int l = 0; l < int'(LANES); l++) begin
                  out_d[l] = crc_q[l][CRC_W-1];
                  crc_d[l] = {crc_q[l][CRC_W-2:0], 1'b0};
               end
            end
`ifdef SD_CRC_CHECK_EN
            // out_q holds the CRC bit being presented this cycle.
            if (chk_q) begin
               err_d = err_q | (bus_io.din ^ out_q);
            end
`endif
         end

         StEndb: begin
            done_d  = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
            crc_d   = '0;
`ifdef SD_CRC_CHECK_EN
            if (chk_q) begin
               err_d = err_q | ~bus_io.din;
            end
            chk_d = 1'b0;
`endif
         end

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            crc_d   = '0;
         end
      endcase

      if (bus_io.clr) begin
         state_d   = StIdle;
         cnt_d     = '0;
         crc_d     = '0;
         out_d     = '0;
         out_vld_d = 1'b0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
`ifdef SD_CRC_CHECK_EN
         chk_d     = 1'b0;
         err_d     = '0;
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         crc_q     <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef SD_CRC_CHECK_EN
         chk_q     <= 1'b0;
         err_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         crc_q     <= crc_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef SD_CRC_CHECK_EN
         chk_q     <= chk_d;
         err_q     <= err_d;
`endif
      end
   end

   assign bus_io.dout    = out_q;
   assign bus_io.out_vld = out_vld_q;
   assign bus_io.busy    = busy_q;
   assign bus_io.done    = done_q;
   assign bus_io.crc     = crc_q;
`ifdef SD_CRC_CHECK_EN
   assign bus_io.err     = err_q;
`endif

endmodule

// File: tb/tb_sd_crc_gen.sv
// tb_sd_crc_gen: directed bench for sd_crc_gen in CMD (CRC7 x1) and DAT (CRC16 x4, x1) setups.
module tb_sd_crc_gen;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sd_crc_gen_if #(.CRC_W(7),  .LANES(1)) c_if  ();
   sd_crc_gen_if #(.CRC_W(16), .LANES(4)) d4_if ();
   sd_crc_gen_if #(.CRC_W(16), .LANES(1)) d1_if ();

   sd_crc_gen #(.CRC_W(7), .POLY(7'h09), .LANES(1)) u_cmd (
      .clk_i (clk),
      .rst_i (rst),
      .bus_io(c_if)
   );

   sd_crc_gen #(.CRC_W(16), .POLY(16'h1021), .LANES(4)) u_dat4 (
      .clk_i (clk),
      .rst_i (rst),
      .bus_io(d4_if)
   );

   sd_crc_gen #(.CRC_W(16), .POLY(16'h1021), .LANES(1)) u_dat1 (
      .clk_i (clk),
      .rst_i (rst),
      .bus_io(d1_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [39:0] payload;
      int          nbits;
      logic [6:0]  crc;
      logic [7:0]  frame;
   } cmd_vec_t;

   cmd_vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd_feed(input logic [39:0] p, input int nbits);
      c_if.clr = 1'b1;
      step();
      c_if.clr = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         c_if.en  = 1'b1;
         c_if.din = p[39-i];
         step();
      end
      c_if.en  = 1'b0;
      c_if.din = 1'b0;
   endtask

   // poke marks cycles where FIN/EN are driven while the engine is busy.
   task automatic cmd_collect(input logic [7:0] poke, output logic [7:0] frame,
                              output int nv, output int nb);
      frame = '0;
      nv    = 0;
      nb    = 0;
      for (int k = 0; k < 8; k++) begin
         if (c_if.out_vld) nv++;
         if (c_if.busy) nb++;
         frame = {frame[6:0], c_if.dout};
         c_if.fin = poke[k];
         c_if.en  = poke[k];
         c_if.din = poke[k];
         step();
      end
      c_if.fin = 1'b0;
      c_if.en  = 1'b0;
      c_if.din = 1'b0;
   endtask

   task automatic d4_shift(input string tag, input logic [63:0] exp);
      logic [63:0] frs;
      int          nv;
      chk({tag, "_crc"}, d4_if.crc, exp);
      d4_if.fin = 1'b1;
      step();
      d4_if.fin = 1'b0;
      frs = '0;
      nv  = 0;
      for (int k = 0; k < 17; k++) begin
         if (d4_if.out_vld) nv++;
         if (k < 16) begin
            for (int l = 0; l < 4; l++) begin
               frs[l*16 +: 16] = {frs[l*16 +: 15], d4_if.dout[l]};
            end
         end else begin
            chk({tag, "_endbit"}, 64'(d4_if.dout), 64'hF);
         end
         step();
      end
      chk({tag, "_frames"}, frs, exp);
      chk({tag, "_vld_cycles"}, 64'(nv), 64'd17);
      chk({tag, "_done"}, 64'(d4_if.done), 64'd1);
      chk({tag, "_crc_post"}, d4_if.crc, 64'd0);
      step();
   endtask

   task automatic d1_collect(input string tag, input logic [15:0] exp);
      logic [15:0] fr;
      int          nv;
      fr = '0;
      nv = 0;
      for (int k = 0; k < 17; k++) begin
         if (d1_if.out_vld) nv++;
         if (k < 16) fr = {fr[14:0], d1_if.dout};
         else chk({tag, "_endbit"}, 64'(d1_if.dout), 64'd1);
         step();
      end
      chk({tag, "_frame"}, 64'(fr), 64'(exp));
      chk({tag, "_vld_cycles"}, 64'(nv), 64'd17);
      chk({tag, "_done"}, 64'(d1_if.done), 64'd1);
      step();
      chk({tag, "_done_off"}, 64'(d1_if.done), 64'd0);
   endtask

`ifdef SD_CRC_CHECK_EN
   task automatic run_rx(input string tag, input logic [7:0] rx, input logic exp_err);
      cmd_feed(40'h40_0000_0000, 40);
      c_if.chk = 1'b1;
      c_if.fin = 1'b1;
      step();
      c_if.fin = 1'b0;
      c_if.chk = 1'b0;
      for (int k = 0; k < 8; k++) begin
         c_if.din = rx[7-k];
         step();
      end
      c_if.din = 1'b0;
      chk({tag, "_done"}, 64'(c_if.done), 64'd1);
      chk({tag, "_err"}, 64'(c_if.err), 64'(exp_err));
      step();
   endtask
`endif

   initial begin
      logic [71:0] s;
      logic [7:0]  frame;
      int          nv;
      int          nb;
      int          seen_done;
      int          seen_vld;

      vecs[0] = '{payload: 40'h40_0000_0000, nbits: 40, crc: 7'h4A, frame: 8'h95};
      vecs[1] = '{payload: 40'h51_0000_0000, nbits: 40, crc: 7'h2A, frame: 8'h55};
      vecs[2] = '{payload: 40'h48_0000_01AA, nbits: 40, crc: 7'h43, frame: 8'h87};
      vecs[3] = '{payload: 40'h77_0000_0000, nbits: 40, crc: 7'h32, frame: 8'h65};
      vecs[4] = '{payload: 40'h69_4000_0000, nbits: 40, crc: 7'h3B, frame: 8'h77};
      vecs[5] = '{payload: 40'h00_0000_0000, nbits: 0,  crc: 7'h00, frame: 8'h01};
      s = "123456789";

      rst = 1'b0;
      {c_if.clr, c_if.din, c_if.en, c_if.fin}     = '0;
      {d4_if.clr, d4_if.din, d4_if.en, d4_if.fin} = '0;
      {d1_if.clr, d1_if.din, d1_if.en, d1_if.fin} = '0;
`ifdef SD_CRC_CHECK_EN
      c_if.chk = 1'b0; d4_if.chk = 1'b0; d1_if.chk = 1'b0;
`endif
      #1 rst = 1'b1;
      #1;
      chk("rst_crc", 64'(c_if.crc), 64'd0);
      chk("rst_out", 64'(c_if.dout), 64'd0);
      chk("rst_flags", 64'({c_if.out_vld, c_if.busy, c_if.done}), 64'd0);
      chk("rst_d4_crc", d4_if.crc, 64'd0);
      step();
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++) begin
         cmd_feed(vecs[i].payload, vecs[i].nbits);
         chk($sformatf("cmd%0d_crc", i), 64'(c_if.crc), 64'(vecs[i].crc));
         chk($sformatf("cmd%0d_idle_busy", i), 64'(c_if.busy), 64'd0);
         c_if.fin = 1'b1;
         step();
         c_if.fin = 1'b0;
         cmd_collect(8'h00, frame, nv, nb);
         chk($sformatf("cmd%0d_frame", i), 64'(frame), 64'(vecs[i].frame));
         chk($sformatf("cmd%0d_vld_cycles", i), 64'(nv), 64'd8);
         chk($sformatf("cmd%0d_busy_cycles", i), 64'(nb), 64'd8);
         chk($sformatf("cmd%0d_done", i), 64'({c_if.done, c_if.out_vld}), 64'b10);
         chk($sformatf("cmd%0d_crc_post", i), 64'(c_if.crc), 64'd0);
         step();
         chk($sformatf("cmd%0d_done_off", i), 64'({c_if.done, c_if.busy}), 64'd0);
      end

      // FIN/EN while busy (mid-SHIFT and in ENDB) must neither disturb nor queue.
      cmd_feed(40'h40_0000_0000, 40);
      c_if.fin = 1'b1;
      step();
      c_if.fin = 1'b0;
      cmd_collect(8'b0010_0001, frame, nv, nb);
      chk("finbusy_frame", 64'(frame), 64'h95);
      chk("finbusy_done", 64'(c_if.done), 64'd1);
      step();
      step();
      chk("finbusy_not_queued", 64'({c_if.busy, c_if.out_vld}), 64'd0);

      // CLR in SHIFT cycle 5 aborts with no DONE.
      cmd_feed(40'h40_0000_0000, 40);
      c_if.fin = 1'b1;
      step();
      c_if.fin = 1'b0;
      for (int k = 0; k < 5; k++) step();
      c_if.clr = 1'b1;
      step();
      c_if.clr = 1'b0;
      chk("clr_flags", 64'({c_if.out_vld, c_if.busy, c_if.done, c_if.dout}), 64'd0);
      chk("clr_crc", 64'(c_if.crc), 64'd0);
      seen_done = 0;
      seen_vld  = 0;
      for (int k = 0; k < 12; k++) begin
         if (c_if.done) seen_done++;
         if (c_if.out_vld) seen_vld++;
         step();
      end
      chk("clr_no_done", 64'(seen_done), 64'd0);
      chk("clr_no_vld", 64'(seen_vld), 64'd0);

      // Asynchronous reset mid-CALC, checked before the next clock edge.
      cmd_feed(40'h51_0000_0000, 12);
      rst = 1'b1;
      #1;
      chk("rstcalc_crc", 64'(c_if.crc), 64'd0);
      chk("rstcalc_flags", 64'({c_if.out_vld, c_if.busy, c_if.done, c_if.dout}), 64'd0);
      step();
      rst = 1'b0;
      cmd_feed(40'h40_0000_0000, 40);
      chk("rstcalc_recover_crc", 64'(c_if.crc), 64'h4A);

      // DAT x4: 512 bytes of 0xFF per lane.
      d4_if.clr = 1'b1;
      step();
      d4_if.clr = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         d4_if.en  = 1'b1;
         d4_if.din = 4'hF;
         step();
      end
      d4_if.en  = 1'b0;
      d4_if.din = 4'h0;
      d4_shift("dat4_ff", 64'h7FA1_7FA1_7FA1_7FA1);

      // DAT x4: "123456789" on lane 2 only; other lanes stay zero.
      d4_if.clr = 1'b1;
      step();
      d4_if.clr = 1'b0;
      for (int i = 0; i < 72; i++) begin
         d4_if.en  = 1'b1;
         d4_if.din = {1'b0, s[71-i], 2'b00};
         step();
      end
      d4_if.en  = 1'b0;
      d4_if.din = 4'h0;
      d4_shift("dat4_lane2", 64'h0000_31C3_0000_0000);

      // DAT x1: check string with separate FIN.
      d1_if.clr = 1'b1;
      step();
      d1_if.clr = 1'b0;
      for (int i = 0; i < 72; i++) begin
         d1_if.en  = 1'b1;
         d1_if.din = s[71-i];
         step();
      end
      d1_if.en  = 1'b0;
      d1_if.din = 1'b0;
      chk("dat1_crc", 64'(d1_if.crc), 64'h31C3);
      d1_if.fin = 1'b1;
      step();
      d1_if.fin = 1'b0;
      d1_collect("dat1", 16'h31C3);

      // DAT x1: EN and FIN together on the last bit.
      d1_if.clr = 1'b1;
      step();
      d1_if.clr = 1'b0;
      for (int i = 0; i < 71; i++) begin
         d1_if.en  = 1'b1;
         d1_if.din = s[71-i];
         step();
      end
      d1_if.din = s[0];
      d1_if.fin = 1'b1;
      step();
      d1_if.en  = 1'b0;
      d1_if.fin = 1'b0;
      d1_if.din = 1'b0;
      chk("dat1_enfin_vld", 64'(d1_if.out_vld), 64'd1);
      d1_collect("dat1_enfin", 16'h31C3);

`ifdef SD_CRC_CHECK_EN
      run_rx("rx_good", 8'h95, 1'b0);
      run_rx("rx_bit3", 8'h85, 1'b1);
      run_rx("rx_endbit", 8'h94, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
